// File: rtl/dmem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : dmem_arb_pkg
// Desc     : Shared identifiers and default sizes for the data-memory arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

  // Requester identifier: one bit selects between the two ports.
  typedef logic arb_id_t;

  localparam arb_id_t ID_CPU    = 1'b0;
  localparam arb_id_t ID_LOADER = 1'b1;

  localparam int DMEM_AW        = 32;
  localparam int DMEM_DW        = 32;
  localparam int DMEM_MAX_BURST = 4;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_pick.sv
//------------------------------------------------------------------------------
// Module   : dmem_arb_pick
// Desc     : Combinational grant picker. An eligible lock owner wins first;
//            otherwise contention is resolved round-robin (or port 0 always
//            wins when DMEM_ARB_FIXED_PRI_EN is defined); a lone requester
//            is always granted.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_id_t    last_gnt,
  input  arb_id_t    lock_own,
  input  logic       lock_ok,
  output logic [1:0] gnt
);

  // Priority chain: lock holder, then contention rule, then single requester.
  always_comb begin
    gnt = 2'b00;
    if (lock_ok && req[lock_own]) begin
      gnt[lock_own] = 1'b1;
    end else if (&req) begin
`ifdef DMEM_ARB_FIXED_PRI_EN
      gnt = 2'b01;
`else
      gnt = (last_gnt == ID_CPU) ? 2'b10 : 2'b01;
`endif
    end else begin
      gnt = req;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : dmem_arbiter
// Desc     : Two-port arbiter in front of the single-port data memory.
//            Round-robin with bounded burst locking, 1-cycle read return
//            routed to the issuing port. Optional macro
//            DMEM_ARB_FIXED_PRI_EN makes port 0 win every contention.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = DMEM_AW,
  parameter int DW        = DMEM_DW,
  parameter int MAX_BURST = DMEM_MAX_BURST
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic          mem_r,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

  arb_id_t    r_last_gnt;
  logic       r_lock_v;
  arb_id_t    r_lock_own;
  logic [3:0] r_burst_cnt;
  logic       r_rd_tag_v;
  arb_id_t    r_rd_tag_id;

  logic [1:0] w_pick;
  logic [1:0] w_gnt;
  logic       w_lock_ok;
  logic       w_any;
  arb_id_t    w_sel;
  logic       w_we;
  logic       w_lock;

  // The lock is only honoured while the owner still has burst budget left.
  assign w_lock_ok = r_lock_v && (r_burst_cnt < C_MAX_BURST);

  dmem_arb_pick u_pick (
    .req      ({m1_req, m0_req}),
    .last_gnt (r_last_gnt),
    .lock_own (r_lock_own),
    .lock_ok  (w_lock_ok),
    .gnt      (w_pick)
  );

  // Grants are forced low while reset is held so the memory sees no command.
  assign w_gnt  = w_pick & {2{~rst}};
  assign m0_gnt = w_gnt[0];
  assign m1_gnt = w_gnt[1];
  assign w_any  = |w_gnt;
  assign w_sel  = w_gnt[1] ? ID_LOADER : ID_CPU;

  // Command mux: port 0 values pass through when idle (don't-care).
  assign w_we      = w_gnt[1] ? m1_we    : m0_we;
  assign w_lock    = w_gnt[1] ? m1_lock  : m0_lock;
  assign mem_addr  = w_gnt[1] ? m1_addr  : m0_addr;
  assign mem_wdata = w_gnt[1] ? m1_wdata : m0_wdata;
  assign mem_r     = w_any & ~w_we;
  assign mem_w     = w_any &  w_we;

  // Read data is shared; the tag decides which port sees it as valid.
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign m0_rvalid = r_rd_tag_v && (r_rd_tag_id == ID_CPU);
  assign m1_rvalid = r_rd_tag_v && (r_rd_tag_id == ID_LOADER);

  // Arbitration history, burst lock tracking and read-return tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt  <= ID_LOADER;
      r_lock_v    <= 1'b0;
      r_lock_own  <= ID_CPU;
      r_burst_cnt <= 4'd0;
      r_rd_tag_v  <= 1'b0;
      r_rd_tag_id <= ID_CPU;
    end else begin
      r_rd_tag_v <= mem_r;
      if (mem_r) begin
        r_rd_tag_id <= w_sel;
      end
      if (w_any) begin
        r_last_gnt <= w_sel;
        if (w_lock) begin
          r_lock_v   <= 1'b1;
          r_lock_own <= w_sel;
          if (r_lock_v && (r_lock_own == w_sel)) begin
            // Saturate at the cap: any value >= MAX_BURST behaves the same.
            if (r_burst_cnt < C_MAX_BURST) begin
              r_burst_cnt <= r_burst_cnt + 4'd1;
            end
          end else begin
            r_burst_cnt <= 4'd1;
          end
        end else begin
          r_lock_v    <= 1'b0;
          r_burst_cnt <= 4'd0;
        end
      end else begin
        // An idle cycle (owner dropped req) always releases the lock.
        r_lock_v    <= 1'b0;
        r_burst_cnt <= 4'd0;
      end
    end
  end

endmodule

`default_nettype wire
